// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, covers the 1-cycle memory read latency and
// hands {PC, instruction} to decode through a 2-entry buffer, with redirect/flush.
module instr_fetch_unit #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                  IFU_Clk,
    input  logic                  IFU_Reset,
    output logic [ADDR_WIDTH-1:0] IFU_Mem_Address,
    output logic                  IFU_Mem_Re,
    input  logic [31:0]           IFU_Mem_Data,
    input  logic                  IFU_Redirect_Valid,
    input  logic [31:0]           IFU_Redirect_Pc,
    output logic                  IFU_Instr_Valid,
    output logic [31:0]           IFU_Instr,
    output logic [31:0]           IFU_Pc,
    input  logic                  IFU_Instr_Ready
);

    logic [31:0] req_pc_q;
    logic [31:0] inflight_pc_q;
    logic        inflight_q;
    logic        kill_q;
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_instr_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  credit;

    assign pop    = IFU_Instr_Valid & IFU_Instr_Ready;
    // Buffered plus in-flight entries after this cycle's pop; never underflows since pop needs count>0.
    assign credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = ~IFU_Redirect_Valid & (credit < 3'd2);
    assign push   = inflight_q & ~kill_q;

    always_ff @(posedge IFU_Clk or posedge IFU_Reset) begin
        if (IFU_Reset) begin
            req_pc_q      <= RESET_VECTOR;
            inflight_pc_q <= 32'h0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else if (IFU_Redirect_Valid) begin
            req_pc_q   <= IFU_Redirect_Pc & ~32'h3;
            kill_q     <= inflight_q;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            kill_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= req_pc_q;
                req_pc_q      <= req_pc_q + 32'd4;
            end
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge IFU_Clk or posedge IFU_Reset) begin
        if (IFU_Reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]    <= 32'h0;
                buf_instr_q[i] <= 32'h0;
            end
        end else if (push && !IFU_Redirect_Valid) begin
            buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
            buf_instr_q[wr_ptr_q] <= IFU_Mem_Data;
        end
    end

    assign IFU_Mem_Address = req_pc_q[ADDR_WIDTH-1:0];
    // Memory gates its read data with Re, so it must be high whenever out of reset.
    assign IFU_Mem_Re      = ~IFU_Reset;
    assign IFU_Instr_Valid = (count_q != 2'd0);
    assign IFU_Instr       = buf_instr_q[rd_ptr_q];
    assign IFU_Pc          = buf_pc_q[rd_ptr_q];

    // The credit check must make a push into a full buffer impossible.
    push_not_full_a : assert property (@(posedge IFU_Clk) disable iff (IFU_Reset)
        (push && count_q == 2'd2) |-> (pop || IFU_Redirect_Valid));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then a randomized run
// checked against a stream-level model (expected next PC, flush latency, hold stability).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ready;

    logic [9:0]  addr_a, addr_w;
    logic        re_a, re_w;
    logic [31:0] data_a, data_w;
    logic        valid_a, valid_w;
    logic [31:0] instr_a, instr_w, pc_a, pc_w;

    logic [31:0] mem [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re_a) data_a <= mem[addr_a[9:2]];
        if (re_w) data_w <= mem[addr_w[9:2]];
    end

    instr_fetch_unit #(.ADDR_WIDTH(10), .RESET_VECTOR(32'h0000_0000)) dut (
        .IFU_Clk            (clk),
        .IFU_Reset          (rst),
        .IFU_Mem_Address    (addr_a),
        .IFU_Mem_Re         (re_a),
        .IFU_Mem_Data       (data_a),
        .IFU_Redirect_Valid (redir),
        .IFU_Redirect_Pc    (redir_pc),
        .IFU_Instr_Valid    (valid_a),
        .IFU_Instr          (instr_a),
        .IFU_Pc             (pc_a),
        .IFU_Instr_Ready    (ready)
    );

    instr_fetch_unit #(.ADDR_WIDTH(10), .RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
        .IFU_Clk            (clk),
        .IFU_Reset          (rst),
        .IFU_Mem_Address    (addr_w),
        .IFU_Mem_Re         (re_w),
        .IFU_Mem_Data       (data_w),
        .IFU_Redirect_Valid (1'b0),
        .IFU_Redirect_Pc    (32'h0),
        .IFU_Instr_Valid    (valid_w),
        .IFU_Instr          (instr_w),
        .IFU_Pc             (pc_w),
        .IFU_Instr_Ready    (1'b1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Head entry must be valid and match the model's PC and memory contents.
    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, valid_a}, 32'd1);
        check({tag, "_pc"}, pc_a, pc);
        check({tag, "_instr"}, instr_a, mem[pc[9:2]]);
    endtask

    // Issue a redirect (ready held high) and verify the 2-edge refill with the new stream.
    task automatic redirect_and_check(input string tag, input logic [31:0] target);
        logic [31:0] base;
        base     = target & ~32'h3;
        redir    = 1'b1;
        redir_pc = target;
        step();
        redir = 1'b0;
        check({tag, "_flush0"}, {31'b0, valid_a}, 32'd0);
        step();
        check({tag, "_flush1"}, {31'b0, valid_a}, 32'd0);
        step();
        check_head({tag, "_h0"}, base);
        step();
        check_head({tag, "_h1"}, base + 32'd4);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_pc, prev_instr;
        logic        prev_hold;
        int          since_redir;

        for (int i = 0; i < 256; i++) mem[i] = i;
        rst      = 1'b1;
        redir    = 1'b0;
        redir_pc = 32'h0;
        ready    = 1'b1;
        repeat (2) step();

        check("rst_valid", {31'b0, valid_a}, 32'd0);
        check("rst_re", {31'b0, re_a}, 32'd0);
        check("rst_pc", pc_a, 32'd0);
        check("rst_instr", instr_a, 32'd0);

        // 1: first fetch latency and one-per-cycle streaming; wrap instance in parallel
        rst = 1'b0;
        #1;
        check("t1_re", {31'b0, re_a}, 32'd1);
        check("t1_addr", {22'b0, addr_a}, 32'h0);
        check("t5_addr", {22'b0, addr_w}, 32'h3F8);
        step();
        check("t1_lat_edge1", {31'b0, valid_a}, 32'd0);
        step();
        check_head("t1_first", 32'h0);
        check("t5_pc0", pc_w, 32'hFFFF_FFF8);
        check("t5_in0", instr_w, mem[254]);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_head("t1_stream", 32'(k * 4));
            if (k == 1) begin
                check("t5_pc1", pc_w, 32'hFFFF_FFFC);
                check("t5_in1", instr_w, mem[255]);
            end
            if (k == 2) begin
                check("t5_pc2", pc_w, 32'h0);
                check("t5_in2", instr_w, mem[0]);
            end
        end

        // 2: stall at 0x10 for 5 cycles, then resume without gap or duplicate
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_head("t2_hold", 32'h10);
            check("t2_addr", {22'b0, addr_a}, 32'h18);
        end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head("t2_resume", 32'(32'h10 + k * 4));
            step();
        end

        // 3: redirect while a response is in flight, same cycle as a pop
        redirect_and_check("t3", 32'h40);

        // 4: unaligned redirect, then back-to-back redirects
        redirect_and_check("t4a", 32'h103);
        redir    = 1'b1;
        redir_pc = 32'h20;
        step();
        redirect_and_check("t4b", 32'h80);

        // 6: stall to fill the buffer, then reset asynchronously mid-cycle
        ready = 1'b0;
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", {31'b0, valid_a}, 32'd0);
        check("t6_async_re", {31'b0, re_a}, 32'd0);
        step();
        rst   = 1'b0;
        ready = 1'b1;
        step();
        check("t6_lat", {31'b0, valid_a}, 32'd0);
        step();
        check_head("t6_restart", 32'h0);

        // Randomized run against the stream model
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        exp_pc      = 32'h0;
        since_redir = 10;
        prev_hold   = 1'b0;
        prev_pc     = 32'h0;
        prev_instr  = 32'h0;
        ready       = 1'b0;
        // A fresh sample of the head is needed because the memory was just rewritten.
        step();
        exp_pc = pc_a;
        if (exp_pc != 32'h0) begin
            checks++;
            failures++;
            $error("FAIL rnd_start_pc observed=%h expected=%h", pc_a, 32'h0);
        end
        redir    = 1'b1;
        redir_pc = 32'h0;
        step();
        redir       = 1'b0;
        since_redir = 1;
        exp_pc      = 32'h0;
        for (int c = 0; c < 600; c++) begin
            if (since_redir == 1 || since_redir == 2) begin
                check("rnd_flush", {31'b0, valid_a}, 32'd0);
            end else begin
                check("rnd_valid", {31'b0, valid_a}, 32'd1);
                if (since_redir == 3) check("rnd_redir_pc", pc_a, exp_pc);
            end
            if (prev_hold) begin
                check("rnd_hold_pc", pc_a, prev_pc);
                check("rnd_hold_instr", instr_a, prev_instr);
            end
            if (since_redir >= 3 && $urandom_range(0, 15) == 0) begin
                redir       = 1'b1;
                redir_pc    = $urandom;
                ready       = 1'b0;
                exp_pc      = redir_pc & ~32'h3;
                since_redir = 0;
                prev_hold   = 1'b0;
            end else begin
                redir = 1'b0;
                ready = ($urandom_range(0, 3) != 0);
                if (valid_a && ready) begin
                    check("rnd_pop_pc", pc_a, exp_pc);
                    check("rnd_pop_instr", instr_a, mem[exp_pc[9:2]]);
                    exp_pc = exp_pc + 32'd4;
                end
                prev_hold  = valid_a && !ready;
                prev_pc    = pc_a;
                prev_instr = instr_a;
            end
            step();
            since_redir++;
        end
        redir = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
